// File: rtl/sample_ringbuf_if.sv
// sample_ringbuf_if: bundle of the sample FIFO's handshake and status signals.
//   master modport : upstream writer + resampler reader (drive push/pop/offset/clr)
//   slave modport  : sample_ringbuf itself (drives data/fill/status/flags)
// Signals:
//   push_i, wdata_i   write one sample
//   pop_i, offset_i   discard oldest / select sample by age (0 = oldest)
//   clr_i             clear sticky flags
//   data_o            combinational read of the selected sample
//   fill_o, full_o, primed_o, overflow_o, underflow_o  status
interface sample_ringbuf_if #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 24,
    parameter int OFFSET_W   = 4
);
    logic                  push_i;
    logic [WIDTH-1:0]      wdata_i;
    logic                  full_o;
    logic                  pop_i;
    logic [OFFSET_W-1:0]   offset_i;
    logic [WIDTH-1:0]      data_o;
    logic [DEPTH_LOG2:0]   fill_o;
    logic                  primed_o;
    logic                  clr_i;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output push_i, wdata_i, pop_i, offset_i, clr_i,
        input  full_o, data_o, fill_o, primed_o, overflow_o, underflow_o
    );

    modport slave (
        input  push_i, wdata_i, pop_i, offset_i, clr_i,
        output full_o, data_o, fill_o, primed_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/sample_ringbuf.sv
// sample_ringbuf: single-channel sample FIFO feeding the resampler FIR.
// Upstream pushes one sample at a time; the resampler reads any of the oldest
// 2^OFFSET_W samples by offset (combinational) and pops the oldest.
// Ports:
//   clk  single clock, all state on posedge
//   rst  synchronous active-high reset (pointers, fill, flags; not memory)
//   rb   sample_ringbuf_if.slave - push/pop/offset/clr in, data/status out
module sample_ringbuf #(
    parameter int DEPTH_LOG2 = 5,
    parameter int WIDTH      = 24,
    parameter int OFFSET_W   = 4,
    parameter int PRIME      = 16
) (
    input  logic            clk,
    input  logic            rst,
    sample_ringbuf_if.slave rb
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] PRIME_LVL = (DEPTH_LOG2+1)'(PRIME);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   fill_q, fill_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  full;
    logic                  pop_acc;
    logic                  push_acc;
    logic [DEPTH_LOG2-1:0] rd_idx;

    assign full     = (fill_q == FULL_LVL);
    assign pop_acc  = rb.pop_i && (fill_q != '0);
    // A pop in the same cycle frees the slot being written when full.
    assign push_acc = rb.push_i && (!full || pop_acc);

    // Index add wraps naturally at DEPTH_LOG2 bits.
    assign rd_idx = rptr_q + DEPTH_LOG2'(rb.offset_i);

    always_comb begin
        rb.data_o = '0;
        // Offsets past the fill level read as silence.
        if ((DEPTH_LOG2+1)'(rb.offset_i) < fill_q)
            rb.data_o = mem_q[rd_idx];
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        if (push_acc) wptr_d = wptr_q + 1'b1;
        if (pop_acc)  rptr_d = rptr_q + 1'b1;
        if (push_acc && !pop_acc)      fill_d = fill_q + 1'b1;
        else if (pop_acc && !push_acc) fill_d = fill_q - 1'b1;
        // New events win over a same-cycle clear.
        ovf_d = (ovf_q && !rb.clr_i) || (rb.push_i && !push_acc);
        unf_d = (unf_q && !rb.clr_i) || (rb.pop_i && !pop_acc);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    // Storage is not reset; fill gating on the read side hides stale data.
    always_ff @(posedge clk) begin
        if (!rst && push_acc)
            mem_q[wptr_q] <= rb.wdata_i;
    end

    assign rb.full_o      = full;
    assign rb.fill_o      = fill_q;
    assign rb.primed_o    = (fill_q >= PRIME_LVL);
    assign rb.overflow_o  = ovf_q;
    assign rb.underflow_o = unf_q;
endmodule

// File: tb/tb_sample_ringbuf.sv
module tb_sample_ringbuf;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    sample_ringbuf_if #(.DEPTH_LOG2(5), .WIDTH(24), .OFFSET_W(4)) rb ();

    sample_ringbuf #(.DEPTH_LOG2(5), .WIDTH(24), .OFFSET_W(4), .PRIME(16)) dut (
        .clk (clk),
        .rst (rst),
        .rb  (rb.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock with the given inputs, then back to idle; returns #1 after the edge.
    task automatic cyc(input logic p, input logic [23:0] wd, input logic po,
                       input logic c, input logic r);
        rb.push_i  = p;
        rb.wdata_i = wd;
        rb.pop_i   = po;
        rb.clr_i   = c;
        rst        = r;
        @(posedge clk);
        #1;
        rb.push_i = 1'b0;
        rb.pop_i  = 1'b0;
        rb.clr_i  = 1'b0;
        rst       = 1'b0;
    endtask

    // Combinational read; callers keep push/pop idle while reading.
    task automatic rd(input int off, input logic [23:0] exp, input string tag);
        rb.offset_i = 4'(off);
        #1;
        chk(tag, 32'(rb.data_o), 32'(exp));
    endtask

    initial begin
        rb.push_i = 0; rb.wdata_i = 0; rb.pop_i = 0; rb.offset_i = 0; rb.clr_i = 0;

        // Reset state
        cyc(0, 0, 0, 0, 1);
        chk("rst_fill", 32'(rb.fill_o), 0);
        chk("rst_full", 32'(rb.full_o), 0);
        chk("rst_primed", 32'(rb.primed_o), 0);
        chk("rst_ovf", 32'(rb.overflow_o), 0);
        chk("rst_unf", 32'(rb.underflow_o), 0);
        rd(0, 24'h0, "rst_data");

        // Three pushes
        for (int i = 1; i <= 3; i++) cyc(1, 24'(i), 0, 0, 0);
        chk("p3_fill", 32'(rb.fill_o), 3);
        rd(0, 24'h000001, "p3_off0");
        rd(1, 24'h000002, "p3_off1");
        rd(2, 24'h000003, "p3_off2");
        rd(3, 24'h000000, "p3_off3");

        // Primed threshold
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 15; i++) cyc(1, 24'(i), 0, 0, 0);
        chk("pr_before", 32'(rb.primed_o), 0);
        cyc(1, 24'd16, 0, 0, 0);
        chk("pr_after16", 32'(rb.primed_o), 1);
        cyc(0, 0, 1, 0, 0);
        chk("pr_pop", 32'(rb.primed_o), 0);
        chk("pr_pop_fill", 32'(rb.fill_o), 15);
        rd(0, 24'd2, "pr_pop_off0");

        // Overflow
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 31; i++) cyc(1, 24'(32'h100 + i), 0, 0, 0);
        chk("of_full31", 32'(rb.full_o), 0);
        cyc(1, 24'h120, 0, 0, 0);
        chk("of_full32", 32'(rb.full_o), 1);
        chk("of_fill32", 32'(rb.fill_o), 32);
        chk("of_ovf32", 32'(rb.overflow_o), 0);
        cyc(1, 24'h121, 0, 0, 0);
        chk("of_ovf33", 32'(rb.overflow_o), 1);
        chk("of_fill33", 32'(rb.fill_o), 32);
        rd(0, 24'h101, "of_off0");
        rd(15, 24'h110, "of_off15");
        cyc(1, 24'h999, 1, 0, 0);
        chk("of_pp_fill", 32'(rb.fill_o), 32);
        chk("of_pp_full", 32'(rb.full_o), 1);
        chk("of_pp_ovf", 32'(rb.overflow_o), 1);
        rd(0, 24'h102, "of_pp_off0");
        rd(14, 24'h110, "of_pp_off14");
        rd(15, 24'h111, "of_pp_off15");

        // Wrap-around with fill held at 8
        cyc(0, 0, 0, 0, 1);
        for (int k = 0; k < 8; k++) cyc(1, 24'(32'h200 + k), 0, 0, 0);
        for (int j = 0; j < 40; j++) begin
            cyc(1, 24'(32'h208 + j), 1, 0, 0);
            chk("wr_fill", 32'(rb.fill_o), 8);
            for (int k = 0; k < 8; k++)
                rd(k, 24'(32'h200 + j + 1 + k), "wr_off");
        end
        rd(8, 24'h0, "wr_off8");

        // Underflow and clear
        cyc(0, 0, 0, 0, 1);
        cyc(1, 24'hABCDEF, 1, 0, 0);
        chk("uf_flag", 32'(rb.underflow_o), 1);
        chk("uf_fill", 32'(rb.fill_o), 1);
        chk("uf_ovf", 32'(rb.overflow_o), 0);
        rd(0, 24'hABCDEF, "uf_off0");
        cyc(0, 0, 1, 0, 0);
        chk("uf_drain", 32'(rb.fill_o), 0);
        cyc(0, 0, 1, 1, 0);
        chk("uf_clr_set", 32'(rb.underflow_o), 1);
        cyc(0, 0, 0, 1, 0);
        chk("uf_clr", 32'(rb.underflow_o), 0);

        // Reset priority mid-operation
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 1, 0, 0);
        for (int i = 1; i <= 20; i++) cyc(1, 24'(32'h300 + i), 0, 0, 0);
        chk("rs_fill20", 32'(rb.fill_o), 20);
        chk("rs_unf_pre", 32'(rb.underflow_o), 1);
        cyc(1, 24'h777, 1, 1, 1);
        chk("rs_fill", 32'(rb.fill_o), 0);
        chk("rs_full", 32'(rb.full_o), 0);
        chk("rs_primed", 32'(rb.primed_o), 0);
        chk("rs_ovf", 32'(rb.overflow_o), 0);
        chk("rs_unf", 32'(rb.underflow_o), 0);
        for (int k = 0; k < 16; k++) rd(k, 24'h0, "rs_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
